frame_painter: RTL and testbench
================================

# frame_painter

Parametrised rectangle painter that drives the VGA adapter's pixel-write port (oX/oY/oColour/oPlot) from the game FSM. On a start pulse it captures a rectangle and scans it in row-major order, one pixel per clock. Pixels outside the screen are suppressed, and the block reports busy/done. Colour comes either from a solid input or, when compiled in, from an external image ROM, with the ROM read latency compensated.

## Interface
- X_PIXELS, 160, screen width in pixels
- Y_PIXELS, 120, screen height in pixels
- X_W, 8, width of x coordinates and rectangle width
- Y_W, 7, width of y coordinates and rectangle height
- COLOUR_W, 3, colour bits per pixel
- ADDR_W, 15, ROM address width
- ROM_LATENCY, 1, cycles from oRomAddr to valid iRomData (≥1; used only with the ROM feature)

Ports:
- iClock  in  1  clock
- iResetn  in  1  reset; asynchronous and active-low
- iStart  in  1  request a draw; accepted only in IDLE
- iX0  in  X_W  rectangle left column
- iY0  in  Y_W  rectangle top row
- iWidth  in  X_W  rectangle width; 0 means empty
- iHeight  in  Y_W  rectangle height; 0 means empty
- iColour  in  COLOUR_W  solid fill colour
- iBaseAddr  in  ADDR_W  ROM address of the rectangle's first pixel
- oRomAddr  out  ADDR_W  ROM read address
- iRomData  in  COLOUR_W  ROM read data
- oX  out  X_W  pixel column
- oY  out  Y_W  pixel row
- oColour  out  COLOUR_W  pixel colour
- oPlot  out  1  pixel write strobe
- oBusy  out  1  high while in RUN, FLUSH or DONE
- oDone  out  1  one-cycle completion pulse

## Operation
- States and transitions:
  - IDLE: on iStart=1, go to RUN; if iWidth or iHeight is 0, go to DONE instead.
  - RUN: issues one pixel per cycle. After the last pixel it goes to FLUSH.
  - FLUSH: lasts L+1 cycles, then goes to DONE.
  - DONE: lasts 1 cycle, then goes to IDLE.
  - L = ROM_LATENCY when the ROM feature is compiled in, else 0.
- On acceptance, iX0, iY0, iWidth, iHeight, iColour and iBaseAddr are captured. Later input changes have no effect until the next acceptance.
- Scan order:
  - Counters (col,row) start at (0,0).
  - col increments each RUN cycle; at col=width-1 it resets to 0 and row increments.
  - The last pixel is (width-1, height-1).
- Address:
  - Starts at the captured base and increments by 1 per issued pixel, including clipped pixels.
  - Wraps modulo 2^ADDR_W.
  - oRomAddr is held in IDLE/DONE.
- Coordinate arithmetic:
  - Pixel x = x0+col is computed at X_W+1 bits; pixel y = y0+row at Y_W+1 bits.
  - A pixel is clipped when x ≥ X_PIXELS or y ≥ Y_PIXELS.
  - A clipped pixel takes its issue slot but produces oPlot=0.
- Pipeline: coordinates and the plot flag travel through a delay line of L stages, so that oX/oY/oColour/oPlot stay aligned with the ROM data.
- oPlot is 0 whenever no valid in-screen pixel is being output.
- iStart is ignored outside IDLE, including the DONE cycle.
- Reset, including reset mid-draw: state goes to IDLE, all counters clear, pipeline valid bits clear, and the in-progress draw is abandoned.

## Timing
- Reset values: oX=0, oY=0, oColour=0, oPlot=0, oRomAddr=0, oBusy=0, oDone=0.
- Let iStart be sampled in cycle S, and let N = width·height.
  - RUN occupies cycles S+1 .. S+N.
  - The pixel issued in cycle c appears on the outputs in cycle c+L+1. The first pixel therefore appears in S+L+2 and the last in S+N+L+1.
  - oDone=1 in cycle S+N+L+2; oBusy=0 from S+N+L+3.
- Empty rectangle: DONE occupies cycle S+1 with oDone=1 and oBusy=1; no oPlot pulse occurs.
- All outputs are registered.

## Configuration
- FRAME_PAINTER_ROM_EN defined:
  - oColour = iRomData delayed to align with its address.
  - L = ROM_LATENCY.
  - iColour is ignored.
- Not defined:
  - oColour = captured iColour.
  - L = 0.
  - oRomAddr is still generated but is unused by the colour path.

## Test plan
- No macro; start with x0=0, y0=0, w=160, h=120, colour=3'b101.
  - Required: exactly 19200 oPlot pulses, coordinates (0,0) at S+2 through (159,119) at S+19201, all colour 101, oDone at S+19202.
- FRAME_PAINTER_ROM_EN with ROM_LATENCY=2; w=4, h=3 at (10,20), base=100; bench ROM model returns addr[2:0].
  - Required: oRomAddr runs 100..111 in S+1..S+12.
  - Required: 12 plots in S+4..S+15 with oColour = (100+k)[2:0] at (10+k%4, 20+k/4); oDone at S+16.
- Clipping: x0=158, w=4, y0=119, h=2.
  - Required: 8 issue cycles and address advances by 8.
  - Required: only (158,119) and (159,119) are plotted.
- w=0, h=5.
  - Required: no oPlot; oDone and oBusy high at S+1; IDLE at S+2.
- Reset and busy handling:
  - Pull iResetn low at S+50 of a full-screen draw. Required: all outputs read 0 immediately.
  - After release, a new start of w=2, h=1 yields exactly 2 plots.
  - A second iStart pulsed during RUN is ignored.
- Address wrap: base=32766, w=4, h=1.
  - Required: oRomAddr sequence 32766, 32767, 0, 1.

Source files
------------

// File: rtl/frame_painter_if.sv
// Pixel-write bus between the game FSM and frame_painter, plus the image ROM read port.
// Signal names match the VGA adapter / ROM pin names they connect to.
interface frame_painter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 15
);
    logic                iStart;
    logic [X_W-1:0]      iX0;
    logic [Y_W-1:0]      iY0;
    logic [X_W-1:0]      iWidth;
    logic [Y_W-1:0]      iHeight;
    logic [COLOUR_W-1:0] iColour;
    logic [ADDR_W-1:0]   iBaseAddr;
    logic [ADDR_W-1:0]   oRomAddr;
    logic [COLOUR_W-1:0] iRomData;
    logic [X_W-1:0]      oX;
    logic [Y_W-1:0]      oY;
    logic [COLOUR_W-1:0] oColour;
    logic                oPlot;
    logic                oBusy;
    logic                oDone;

    modport master (
        output iStart, iX0, iY0, iWidth, iHeight, iColour, iBaseAddr, iRomData,
        input  oRomAddr, oX, oY, oColour, oPlot, oBusy, oDone
    );

    modport slave (
        input  iStart, iX0, iY0, iWidth, iHeight, iColour, iBaseAddr, iRomData,
        output oRomAddr, oX, oY, oColour, oPlot, oBusy, oDone
    );
endinterface

// File: rtl/frame_painter.sv
// Rectangle painter: scans a captured rectangle row-major, one pixel per clock, clipping off-screen pixels.
// Define FRAME_PAINTER_ROM_EN to take colour from the image ROM (latency ROM_LATENCY) instead of iColour.
module frame_painter #(
    parameter int X_PIXELS    = 160,
    parameter int Y_PIXELS    = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOUR_W    = 3,
    parameter int ADDR_W      = 15,
    parameter int ROM_LATENCY = 1
) (
    input logic            iClock,
    input logic            iResetn,
    frame_painter_if.slave bus
);
`ifdef FRAME_PAINTER_ROM_EN
    localparam bit ROM_EN = 1'b1;
`else
    localparam bit ROM_EN = 1'b0;
`endif
    localparam int STAGES = ROM_EN ? ROM_LATENCY : 0;
    localparam int FC_W   = $clog2(STAGES + 2);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state_q, state_d;

    logic [X_W-1:0]    x0_q, w_q, col_q;
    logic [Y_W-1:0]    y0_q, h_q, row_q;
    logic [ADDR_W-1:0] addr_q;
    logic [FC_W-1:0]   flush_q;
    logic              busy_q, done_q;

    logic              accept, issue, last_col, last_px, empty, on_screen;
    logic [X_W:0]      px_x;
    logic [Y_W:0]      px_y;

    // Pipeline: stage 0 is the issue register, stage STAGES drives the outputs.
    logic [STAGES:0]   vld_pipe;
    logic [X_W-1:0]    x_pipe [0:STAGES];
    logic [Y_W-1:0]    y_pipe [0:STAGES];

    assign empty    = (bus.iWidth == '0) || (bus.iHeight == '0);
    assign last_col = (col_q == w_q - X_W'(1));
    assign last_px  = last_col && (row_q == h_q - Y_W'(1));

    // One extra bit so x0+col / y0+row past the edge cannot wrap back on screen.
    assign px_x      = {1'b0, x0_q} + {1'b0, col_q};
    assign px_y      = {1'b0, y0_q} + {1'b0, row_q};
    assign on_screen = (px_x < (X_W+1)'(X_PIXELS)) && (px_y < (Y_W+1)'(Y_PIXELS));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    accept  = 1'b1;
                    state_d = empty ? DONE : RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (last_px) state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_q == FC_W'(STAGES)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            flush_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            flush_q <= (state_q == FLUSH) ? flush_q + FC_W'(1) : '0;
            if (accept) begin
                x0_q   <= bus.iX0;
                y0_q   <= bus.iY0;
                w_q    <= bus.iWidth;
                h_q    <= bus.iHeight;
                col_q  <= '0;
                row_q  <= '0;
                addr_q <= bus.iBaseAddr;
            end else if (issue) begin
                // Clipped pixels still consume an address so the ROM image stays aligned.
                addr_q <= addr_q + ADDR_W'(1);
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + Y_W'(1);
                end else begin
                    col_q <= col_q + X_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            vld_pipe <= '0;
            for (int i = 0; i <= STAGES; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= issue && on_screen;
            x_pipe[0]   <= px_x[X_W-1:0];
            y_pipe[0]   <= px_y[Y_W-1:0];
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
        end
    end

`ifdef FRAME_PAINTER_ROM_EN
    // ROM data for the pixel issued STAGES cycles ago is valid now; register it with that pixel.
    logic [COLOUR_W-1:0] colour_q;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) colour_q <= '0;
        else          colour_q <= bus.iRomData;
    end

    assign bus.oColour = colour_q;
`else
    logic [COLOUR_W-1:0] fill_q;
    logic [COLOUR_W-1:0] colour_q;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            fill_q   <= '0;
            colour_q <= '0;
        end else begin
            if (accept) fill_q <= bus.iColour;
            colour_q <= fill_q;
        end
    end

    assign bus.oColour = colour_q;
`endif

    assign bus.oX       = x_pipe[STAGES];
    assign bus.oY       = y_pipe[STAGES];
    assign bus.oPlot    = vld_pipe[STAGES];
    assign bus.oRomAddr = addr_q;
    assign bus.oBusy    = busy_q;
    assign bus.oDone    = done_q;
endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: each draw is checked cycle by cycle against a rectangle-scan model.
// Works in both builds; with FRAME_PAINTER_ROM_EN the ROM model supplies colour = addr[2:0].
module tb_frame_painter;
    localparam int ROM_LAT = 2;
`ifdef FRAME_PAINTER_ROM_EN
    localparam int LAT     = ROM_LAT;
    localparam bit USE_ROM = 1'b1;
`else
    localparam int LAT     = 0;
    localparam bit USE_ROM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   addr_seen [1:4];

    frame_painter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .ADDR_W(15)) bus ();

    frame_painter #(
        .X_PIXELS(160), .Y_PIXELS(120), .X_W(8), .Y_W(7),
        .COLOUR_W(3), .ADDR_W(15), .ROM_LATENCY(ROM_LAT)
    ) dut (
        .iClock (clk),
        .iResetn(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ROM model: data = addr[2:0], valid ROM_LAT cycles after the address.
    logic [2:0] rom_pipe [0:ROM_LAT-1];
    always @(posedge clk) begin
        rom_pipe[0] <= bus.oRomAddr[2:0];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.iRomData = rom_pipe[ROM_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic draw(input string tag, input int x0, input int y0, input int w, input int h,
                        input int colour, input int base, input int exp_plots, input bit restart);
        int n, last_j, done_exp, k, x, y, ec;
        int plots, pix_err, addr_err, busy_err, done_j;
        bit ep, eb;
        n = w * h;
        plots = 0; pix_err = 0; addr_err = 0; busy_err = 0; done_j = -1;
        x = 0; y = 0; ec = 0;
        done_exp = (n == 0) ? 1 : n + LAT + 2;
        last_j   = done_exp + 2;
        @(negedge clk);
        bus.iStart    = 1'b1;
        bus.iX0       = 8'(x0);
        bus.iY0       = 7'(y0);
        bus.iWidth    = 8'(w);
        bus.iHeight   = 7'(h);
        bus.iColour   = 3'(colour);
        bus.iBaseAddr = 15'(base);
        for (int j = 1; j <= last_j; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.iStart  = 1'b0;
                bus.iX0     = 8'd1;
                bus.iColour = 3'd0;
            end
            if (restart && j == 2) begin
                bus.iStart   = 1'b1;
                bus.iWidth   = 8'd50;
                bus.iHeight  = 7'd50;
            end
            if (restart && j == 3) bus.iStart = 1'b0;
            ep = 1'b0;
            if (j >= LAT + 2 && j <= n + LAT + 1) begin
                k  = j - LAT - 2;
                x  = x0 + k % w;
                y  = y0 + k / w;
                ep = (x < 160) && (y < 120);
                ec = USE_ROM ? ((base + k) & 7) : colour;
            end
            if (bus.oPlot === 1'b1) plots++;
            if (bus.oPlot !== ep) pix_err++;
            else if (ep && (bus.oX !== 8'(x) || bus.oY !== 7'(y) || bus.oColour !== 3'(ec))) pix_err++;
            if (j <= n && bus.oRomAddr !== 15'(base + j - 1)) addr_err++;
            if (j <= 4) addr_seen[j] = int'(bus.oRomAddr);
            if (bus.oDone === 1'b1) done_j = (done_j < 0) ? j : -2;
            eb = (j <= done_exp);
            if (bus.oBusy !== eb) busy_err++;
        end
        check({tag, "_plots"}, plots, exp_plots);
        check({tag, "_pix_err"}, pix_err, 0);
        check({tag, "_addr_err"}, addr_err, 0);
        check({tag, "_busy_err"}, busy_err, 0);
        check({tag, "_done_cyc"}, done_j, done_exp);
        check({tag, "_addr_end"}, bus.oRomAddr, (base + n) & 32'h7fff);
    endtask

    initial begin
        bus.iStart = 1'b0; bus.iX0 = '0; bus.iY0 = '0; bus.iWidth = '0;
        bus.iHeight = '0; bus.iColour = '0; bus.iBaseAddr = '0;
        repeat (3) @(negedge clk);
        check("rst_plot", bus.oPlot, 0);
        check("rst_busy", bus.oBusy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_x", bus.oX, 0);
        check("rst_y", bus.oY, 0);
        check("rst_colour", bus.oColour, 0);
        check("rst_addr", bus.oRomAddr, 0);
        check("rst_done", bus.oDone, 0);

        draw("full", 0, 0, 160, 120, 5, 0, 19200, 1'b0);
        draw("rom", 10, 20, 4, 3, 2, 100, 12, 1'b0);
        draw("clip", 158, 119, 4, 2, 7, 500, 2, 1'b0);
        draw("empty", 3, 3, 0, 5, 1, 10, 0, 1'b0);

        // Reset in the middle of a full-screen draw.
        @(negedge clk);
        bus.iStart = 1'b1; bus.iX0 = 8'd0; bus.iY0 = 7'd0;
        bus.iWidth = 8'd160; bus.iHeight = 7'd120; bus.iColour = 3'd6; bus.iBaseAddr = 15'd0;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (j == 1) bus.iStart = 1'b0;
        end
        check("mid_plot", bus.oPlot, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_plot", bus.oPlot, 0);
        check("mid_rst_x", bus.oX, 0);
        check("mid_rst_busy", bus.oBusy, 0);
        check("mid_rst_addr", bus.oRomAddr, 0);
        check("mid_rst_colour", bus.oColour, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        draw("restart", 5, 5, 2, 1, 6, 200, 2, 1'b1);

        draw("wrap", 0, 0, 4, 1, 4, 32766, 4, 1'b0);
        check("wrap_a0", addr_seen[1], 32766);
        check("wrap_a1", addr_seen[2], 32767);
        check("wrap_a2", addr_seen[3], 0);
        check("wrap_a3", addr_seen[4], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
